uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx serializer among NUM_REQ byte producers. Arbitration is
//  round-robin at message granularity: the grant is held until the byte tagged
//  req_last is sent. Sequences the serializer via a tx_en pulse and busy-edge
//  tracking. Sits between on-chip producers (status, debug, crypto log) and uart_tx.
// PARAMETERS
//  NUM_REQ        4        number of requesters (2..8)
//  PAYLOAD_WIDTH  8        byte width; must match the serializer
//  WDOG_CYCLES    16       cycles to wait for uart_busy rise (watchdog build only)
// PORTS
//  clk           in   1                      system clock, all logic on posedge
//  rst           in   1                      synchronous reset, active-high
//  req_valid     in   NUM_REQ                per-requester byte valid
//  req_data      in   NUM_REQ*PAYLOAD_WIDTH  byte of requester i at [i*PW +: PW]
//  req_last      in   NUM_REQ                byte is last of message
//  req_ready     out  NUM_REQ                byte accepted (combinational, one-hot)
//  uart_tx_en    out  1                      one-cycle launch pulse to serializer
//  uart_tx_data  out  PAYLOAD_WIDTH          registered byte to serializer
//  uart_busy     in   1                      serializer busy
//  grant_id      out  clog2(NUM_REQ)         current/last owner index
//  grant_active  out  1                      a message owns the UART
//  wdog_err      out  1                      one-cycle pulse on watchdog expiry
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=NUM_REQ-1, grant_id=0, grant_active=0, uart_tx_en=0,
//   uart_tx_data=0, req_ready=0, wdog_err=0, last_q=0, wdog_cnt=0.
//  rst mid-message: abort immediately, no further tx_en, same reset values.
//  States: IDLE, LOAD, SEND, WAIT_BUSY, WAIT_DONE.
//  IDLE: if any req_valid, g = first valid index scanning rr_ptr+1 upward with
//   wrap; grant_id<=g, grant_active<=1, -> LOAD. None valid: stay.
//  LOAD: req_ready[g] = req_valid[g] && !uart_busy (only ready source). On
//   transfer: uart_tx_data<=byte g, last_q<=req_last[g], -> SEND. Else hold
//   (grant stays locked even if req_valid[g] drops mid-message).
//  SEND: uart_tx_en=1 for exactly this cycle, -> WAIT_BUSY.
//  WAIT_BUSY: uart_busy=1 -> WAIT_DONE.
//  WAIT_DONE: uart_busy=0 -> if last_q: rr_ptr<=g, grant_active<=0, IDLE;
//   else LOAD (same g, no re-arbitration).
//  Latency: valid in IDLE (cycle 0) -> ready cycle 1 -> tx_en cycle 2.
//  Back-to-back bytes of one message: next ready 1 cycle after busy falls.
//  Simultaneous requests: rotation guarantees each requester served within
//   NUM_REQ messages; owner of last message has lowest priority next.
//  req_last on a byte with req_valid=0 is ignored; uart_tx_data holds until
//   next transfer. grant_id holds last owner while grant_active=0.
// CONFIGURATION
//  UART_ARB_WATCHDOG_EN defined: WAIT_BUSY counts wdog_cnt from 0; if it
//   reaches WDOG_CYCLES-1 with uart_busy still 0: wdog_err=1 for one cycle,
//   message aborted, rr_ptr<=g, grant_active<=0, -> IDLE. Counter clears on
//   WAIT_BUSY entry.
//  Not defined: WAIT_BUSY waits indefinitely; wdog_err tied 0; no counter.
// TESTING
//  1 Single byte: req_valid[2]=1,data=8'hA5,last=1 -> ready[2] cycle 1, tx_en
//    cycle 2 with uart_tx_data=8'hA5, grant_active drops after busy falls.
//  2 Round-robin: all 4 valid, 1-byte msgs, from reset -> grant order 0,1,2,3,0.
//  3 Lock: req0 sends 3-byte msg (last on byte 3) while req1 valid -> all 3
//    bytes of req0 before any ready[1]; req0 stalls 10 cycles mid-msg, lock held.
//  4 Reset mid-message: rst=1 during WAIT_DONE -> next cycle all outputs reset,
//    no tx_en, rr_ptr=NUM_REQ-1 (next grant to index 0).
//  5 Watchdog (macro on, WDOG_CYCLES=16): busy stuck 0 -> wdog_err pulse 16
//    cycles after tx_en+1, IDLE, next valid requester granted. Macro off: no pulse.
//  6 Busy at LOAD: uart_busy=1 externally -> req_ready held 0 until busy low.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Bus bundle between byte producers / serializer and uart_tx_arbiter.
// Producers drive req_valid/req_data/req_last; the serializer drives uart_busy.
// The arbiter drives everything else.
//
// Handshake: a byte of requester i moves on a rising clk edge where
// req_valid[i] && req_ready[i] are both 1. A producer keeps req_data and
// req_last stable while req_valid is high and the byte is not taken.
// req_ready is combinational and never depends on the byte's own data.
// req_ready has at most one bit set per cycle. uart_tx_en is a one-cycle
// launch strobe with uart_tx_data valid in the same cycle. The serializer
// reports it has accepted the byte by raising uart_busy, and it reports
// that it has finished by dropping uart_busy.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ       = 4,
  parameter int PAYLOAD_WIDTH = 8
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ*PAYLOAD_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]               req_last;
  logic [NUM_REQ-1:0]               req_ready;
  logic                             uart_tx_en;
  logic [PAYLOAD_WIDTH-1:0]         uart_tx_data;
  logic                             uart_busy;
  logic [IDW-1:0]                   grant_id;
  logic                             grant_active;
  logic                             wdog_err;

  // Producer/serializer side
  modport master (
    output req_valid, req_data, req_last, uart_busy,
    input  req_ready, uart_tx_en, uart_tx_data, grant_id, grant_active, wdog_err
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_data, req_last, uart_busy,
    output req_ready, uart_tx_en, uart_tx_data, grant_id, grant_active, wdog_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-granular sharing of one uart_tx
// serializer among NUM_REQ byte producers. A grant is held from the first
// byte of a message until the byte tagged req_last has been sent.
// The owner of the finished message drops to the lowest priority.
// Optional build macro UART_ARB_WATCHDOG_EN enables a watchdog. The watchdog
// aborts the message when the serializer does not raise uart_busy within
// WDOG_CYCLES cycles of the launch.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int PAYLOAD_WIDTH = 8,
  parameter int WDOG_CYCLES   = 16
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus,
  output logic [2:0]        dbg_state_o
);
  localparam int IDW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYCLES < 1) begin : g_param_check
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and WDOG_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } state_e;

  state_e                   state_q, state_d;
  logic [IDW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]           grant_id_q, grant_id_d;
  logic                     grant_active_q, grant_active_d;
  logic [PAYLOAD_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                     last_q, last_d;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     wdog_err;
  logic [PAYLOAD_WIDTH-1:0] req_byte [NUM_REQ];
  logic                     scan_hit;
  logic [IDW-1:0]           scan_idx;

`ifdef UART_ARB_WATCHDOG_EN
  localparam int WCW = $clog2(WDOG_CYCLES + 1);
  logic [WCW-1:0] wdog_cnt_q, wdog_cnt_d;
`endif

  // Split the flat data bus into one byte per requester
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_byte[i] = bus.req_data[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
    end
  end

  // Round-robin scan: first valid requester after rr_ptr, wrapping around
  always_comb begin
    int cand;
    cand     = 0;
    scan_hit = 1'b0;
    scan_idx = '0;
    // Walk from farthest to nearest so the nearest valid index wins
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (bus.req_valid[cand[IDW-1:0]]) begin
        scan_hit = 1'b1;
        scan_idx = cand[IDW-1:0];
      end
    end
  end

  // Next-state and combinational outputs of the sequencing FSM
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_id_d     = grant_id_q;
    grant_active_d = grant_active_q;
    tx_data_d      = tx_data_q;
    last_d         = last_q;
    req_ready      = '0;
    wdog_err       = 1'b0;
`ifdef UART_ARB_WATCHDOG_EN
    wdog_cnt_d     = wdog_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (scan_hit) begin
          grant_id_d     = scan_idx;
          grant_active_d = 1'b1;
          state_d        = LOAD;
        end
      end
      LOAD: begin
        // The grant stays locked here even if the owner drops valid mid-message
        if (bus.req_valid[grant_id_q] && !bus.uart_busy) begin
          req_ready[grant_id_q] = 1'b1;
          tx_data_d             = req_byte[grant_id_q];
          last_d                = bus.req_last[grant_id_q];
          state_d               = SEND;
        end
      end
      SEND: begin
        state_d = WAIT_BUSY;
`ifdef UART_ARB_WATCHDOG_EN
        wdog_cnt_d = '0;
`endif
      end
      WAIT_BUSY: begin
        if (bus.uart_busy) begin
          state_d = WAIT_DONE;
        end
`ifdef UART_ARB_WATCHDOG_EN
        else if (wdog_cnt_q == WCW'(WDOG_CYCLES - 1)) begin
          wdog_err       = 1'b1;
          rr_ptr_d       = grant_id_q;
          grant_active_d = 1'b0;
          state_d        = IDLE;
        end else begin
          wdog_cnt_d = wdog_cnt_q + 1'b1;
        end
`endif
      end
      WAIT_DONE: begin
        if (!bus.uart_busy) begin
          if (last_q) begin
            rr_ptr_d       = grant_id_q;
            grant_active_d = 1'b0;
            state_d        = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset also aborts any message in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      rr_ptr_q       <= IDW'(NUM_REQ - 1);
      grant_id_q     <= '0;
      grant_active_q <= 1'b0;
      tx_data_q      <= '0;
      last_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_id_q     <= grant_id_d;
      grant_active_q <= grant_active_d;
      tx_data_q      <= tx_data_d;
      last_q         <= last_d;
    end
  end

`ifdef UART_ARB_WATCHDOG_EN
  // Watchdog counter, cleared when the FSM enters WAIT_BUSY
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_q <= '0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
    end
  end
`endif

  assign bus.req_ready    = req_ready;
  assign bus.uart_tx_en   = (state_q == SEND);
  assign bus.uart_tx_data = tx_data_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.grant_active = grant_active_q;
  assign bus.wdog_err     = wdog_err;
  assign dbg_state_o      = state_q;
endmodule
